clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider, successor to the fixed divide-by-5 block. Generates a divided clock `clk_out` from `clk_in` for any divisor from 2 to 2^DIV_W−1, with divisor updates applied glitch-free on period boundaries, an enable, and a period-start strobe. It sits in the clock-generation area and feeds low-rate logic and observation points. It also feeds any consumer that needs a `tick` aligned to the divided clock.

---
 rtl/clk_div_prog.sv | 120 ++++++++++++
 tb/tb_clk_div_prog.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog -- runtime-programmable integer clock divider.
//
// Divides clk_in by N (2 .. 2^DIV_W-1). New divisors are staged in a pending
// register and swapped in only on a period boundary (or at once while
// disabled), so clk_out never shows a short or stretched pulse.
//
// Optional feature macro: CLK_DIV_DUTY50_EN
//   defined   : adds one negedge flop; odd divisors get an exact 50% duty.
//   undefined : pure posedge logic; odd N uses an H / N-H duty.
//
// Ports
//   clk_in    in   1      sole clock
//   rst       in   1      synchronous, active-high reset
//   en        in   1      divider enable
//   div_load  in   1      single-cycle request to load div_val
//   div_val   in   DIV_W  requested divisor N
//   clk_out   out  1      divided clock
//   tick      out  1      one-cycle strobe coincident with each clk_out rise
//   div_pend  out  1      accepted divisor waiting for the next boundary
//   div_err   out  1      sticky: last load request was illegal (N<2)
// -----------------------------------------------------------------------------
module clk_div_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic             div_pend,
  output logic             div_err
);

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_cur;
  logic [DIV_W-1:0] r_pend_val;
  logic             r_div_pend;
  logic             r_clk_p;
  logic             r_tick;
  logic             r_div_err;

  logic [DIV_W:0]   w_h;       // high-phase length, one bit wider so N=max doesn't overflow
  logic             w_wrap;
  logic             w_ld_ok;
  logic             w_ld_bad;

  assign w_h      = ({1'b0, r_div_cur} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
  assign w_wrap   = (r_cnt == (r_div_cur - ONE));
  assign w_ld_ok  = div_load && (div_val >= TWO);
  assign w_ld_bad = div_load && (div_val <  TWO);

  // Counter and posedge output flops.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_cnt   <= '0;
      r_clk_p <= 1'b0;
      r_tick  <= 1'b0;
    end else if (en) begin
      r_cnt   <= w_wrap ? '0 : r_cnt + ONE;
      r_clk_p <= ({1'b0, r_cnt} < w_h);
      r_tick  <= (r_cnt == '0);
    end else begin
      r_cnt   <= '0;
      r_clk_p <= 1'b0;
      r_tick  <= 1'b0;
    end
  end

  // Divisor staging. The swap into div_cur is evaluated first so that a load
  // landing on the same edge re-arms the pending slot for the following
  // boundary instead of being consumed by this one.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_div_cur  <= DEF_N;
      r_pend_val <= DEF_N;
      r_div_pend <= 1'b0;
      r_div_err  <= 1'b0;
    end else begin
      if (r_div_pend && (!en || w_wrap)) begin
        r_div_cur  <= r_pend_val;
        r_div_pend <= 1'b0;
      end
      if (w_ld_ok) begin
        r_pend_val <= div_val;
        r_div_pend <= 1'b1;
        r_div_err  <= 1'b0;
      end else if (w_ld_bad) begin
        r_div_err  <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_DUTY50_EN
  // Half-cycle delayed copy of clk_p; ANDing trims the extra high cycle of an
  // odd divisor down to exactly N/2 input periods.
  logic r_clk_n;

  always_ff @(negedge clk_in) begin
    if (rst) r_clk_n <= 1'b0;
    else     r_clk_n <= r_clk_p;
  end

  assign clk_out = r_div_cur[0] ? (r_clk_p & r_clk_n) : r_clk_p;
`else
  assign clk_out = r_clk_p;
`endif

  assign tick     = r_tick;
  assign div_pend = r_div_pend;
  assign div_err  = r_div_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog -- directed self-checking bench for clk_div_prog (default
// build, duty macro undefined). Outputs are sampled 1ns after each posedge;
// inputs are changed in that same window so they are stable at the next edge.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

  localparam int DIV_W = 8;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             en;
  logic             div_load;
  logic [DIV_W-1:0] div_val;
  logic             clk_out;
  logic             tick;
  logic             div_pend;
  logic             div_err;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(5)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .div_load (div_load),
    .div_val  (div_val),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_pend (div_pend),
    .div_err  (div_err)
  );

  always #5 clk_in = ~clk_in;

  // One clock edge, then compare all four outputs.
  task automatic cyc(input string tag, input logic ec, input logic et,
                     input logic ep, input logic ee);
    @(posedge clk_in);
    #1;
    checks++;
    assert (clk_out === ec) else begin
      errors++;
      $error("FAIL %s clk_out got %b exp %b", tag, clk_out, ec);
    end
    checks++;
    assert (tick === et) else begin
      errors++;
      $error("FAIL %s tick got %b exp %b", tag, tick, et);
    end
    checks++;
    assert (div_pend === ep) else begin
      errors++;
      $error("FAIL %s div_pend got %b exp %b", tag, div_pend, ep);
    end
    checks++;
    assert (div_err === ee) else begin
      errors++;
      $error("FAIL %s div_err got %b exp %b", tag, div_err, ee);
    end
  endtask

  // n cycles; patterns are written in time order, leftmost bit first.
  task automatic pat(input string tag, input int n, input logic [31:0] cp,
                     input logic [31:0] tp, input logic ep, input logic ee);
    for (int i = 0; i < n; i++)
      cyc(tag, cp[n-1-i], tp[n-1-i], ep, ee);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;

    // Reset state
    cyc("reset0", 0, 0, 0, 0);
    cyc("reset1", 0, 0, 0, 0);

    // N=5 default: 1,1,1,0,0 with tick on each rise
    rst = 1'b0; en = 1'b1;
    pat("n5", 10, 32'b1110011100, 32'b1000010000, 0, 0);

    // Load N=4 mid-period: old period finishes, then 1,1,0,0
    cyc("n5_a", 1, 1, 0, 0);
    cyc("n5_b", 1, 0, 0, 0);
    div_load = 1'b1; div_val = 8'd4;
    cyc("ld4_a", 1, 0, 1, 0);
    div_load = 1'b0;
    cyc("ld4_b", 0, 0, 1, 0);
    cyc("ld4_wrap", 0, 0, 0, 0);
    pat("n4", 8, 32'b11001100, 32'b10001000, 0, 0);

    // Load 7 then 2 back to back: only 2 applies
    cyc("n4_a", 1, 1, 0, 0);
    div_load = 1'b1; div_val = 8'd7;
    cyc("ld7", 1, 0, 1, 0);
    div_val = 8'd2;
    cyc("ld2", 0, 0, 1, 0);
    div_load = 1'b0;
    cyc("ld2_wrap", 0, 0, 0, 0);
    pat("n2", 4, 32'b1010, 32'b1010, 0, 0);

    // Load coincident with a wrap applies one period later
    cyc("n2_a", 1, 1, 0, 0);
    div_load = 1'b1; div_val = 8'd3;
    cyc("ld3_at_wrap", 0, 0, 1, 0);
    div_load = 1'b0;
    cyc("n2_extra", 1, 1, 1, 0);
    cyc("ld3_wrap", 0, 0, 0, 0);
    pat("n3", 6, 32'b110110, 32'b100100, 0, 0);

    // Illegal loads 0 and 1: error set, divisor unchanged
    div_load = 1'b1; div_val = 8'd0;
    cyc("ld0", 1, 1, 0, 1);
    div_val = 8'd1;
    cyc("ld1", 1, 0, 0, 1);
    div_load = 1'b0;
    cyc("err_hold", 0, 0, 0, 1);
    pat("n3_kept", 3, 32'b110, 32'b100, 0, 1);

    // Legal load clears the error
    div_load = 1'b1; div_val = 8'd3;
    cyc("ld3_clr", 1, 1, 1, 0);
    div_load = 1'b0;
    cyc("ld3_clr_b", 1, 0, 1, 0);
    cyc("ld3_clr_wrap", 0, 0, 0, 0);

    // Drop enable mid-high; load while disabled applies next cycle
    cyc("pre_dis", 1, 1, 0, 0);
    en = 1'b0;
    cyc("dis", 0, 0, 0, 0);
    div_load = 1'b1; div_val = 8'd6;
    cyc("dis_ld6", 0, 0, 1, 0);
    div_load = 1'b0;
    cyc("dis_apply", 0, 0, 0, 0);
    en = 1'b1;
    pat("n6", 7, 32'b1110001, 32'b1000001, 0, 0);

    // Pending load, then illegal load leaves pending intact; reset discards all
    div_load = 1'b1; div_val = 8'd4;
    cyc("rst_ld4", 1, 0, 1, 0);
    div_val = 8'd1;
    cyc("rst_ld1", 1, 0, 1, 1);
    div_load = 1'b0; rst = 1'b1;
    cyc("mid_rst", 0, 0, 0, 0);
    rst = 1'b0;
    pat("post_rst_n5", 11, 32'b11100111001, 32'b10000100001, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
